// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the execute-stage multiply/divide unit:
//   - mdop_e        : 4-bit MDU operation encodings (NONE..MADDU, 9..15 reserved)
//   - CTR_W         : width of the latency down-counter
//   - *_LAT_DEFAULT : default busy-cycle counts for multiply and divide
// Optional feature macro used by the users of this package: MDU_MADD_EN.
// -----------------------------------------------------------------------------
package mdu_pkg;

   typedef enum logic [3:0] {
      MDOP_NONE  = 4'd0,
      MDOP_MULT  = 4'd1,
      MDOP_MULTU = 4'd2,
      MDOP_DIV   = 4'd3,
      MDOP_DIVU  = 4'd4,
      MDOP_MTHI  = 4'd5,
      MDOP_MTLO  = 4'd6,
      MDOP_MADD  = 4'd7,
      MDOP_MADDU = 4'd8
   } mdop_e;

   // Latencies are limited to 1..15 so they fit the counter.
   localparam int CTR_W             = 4;
   localparam int MULT_LAT_DEFAULT  = 5;
   localparam int DIV_LAT_DEFAULT   = 10;

endpackage

// File: rtl/mdu_busy_ctr.sv
// -----------------------------------------------------------------------------
// mdu_busy_ctr
// Latency down-counter for the MDU. Loading a non-zero value starts a busy
// period of exactly that many cycles; done_o marks the last busy cycle, i.e.
// the edge on which the result is written and busy drops.
// Ports:
//   clk        in   clock
//   reset      in   synchronous reset, active low
//   load_i     in   load load_val_i into the counter
//   load_val_i in   latency to load (CTR_W bits)
//   busy_o     out  counter != 0
//   done_o     out  counter == 1 (final busy cycle)
// -----------------------------------------------------------------------------
module mdu_busy_ctr
   import mdu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CTR_W-1:0] load_val_i,
   output logic             busy_o,
   output logic             done_o
);

   logic [CTR_W-1:0] cnt_q;
   logic [CTR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);
   assign done_o = (cnt_q == CTR_W'(1));

endmodule

// File: rtl/mdu_e.sv
// -----------------------------------------------------------------------------
// mdu_e
// Execute-stage multiply/divide unit. Holds the architectural HI/LO registers
// and models multi-cycle mult/div latency with a busy flag. Operands and the
// operation are latched when an op is accepted; the result is computed from
// the latched values and written on the final busy edge.
// Ports:
//   clk    in   pipeline clock
//   reset  in   synchronous reset, active low
//   start  in   E-stage instruction is an MDU op (qualifies mdop)
//   mdop   in   operation code (see mdu_pkg::mdop_e)
//   A, B   in   rs / rt operands (already forwarded)
//   busy   out  operation in flight
//   hi, lo out  current HI / LO registers
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (mdop 7/8),
// which accumulate into {hi,lo} using the values present at completion.
// Without it, mdop 7/8 are reserved and ignored.
// -----------------------------------------------------------------------------
module mdu_e
   import mdu_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEFAULT,
   parameter int DIV_LAT  = DIV_LAT_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CTR_W-1:0] MULT_LAT_C = CTR_W'(MULT_LAT);
   localparam logic [CTR_W-1:0] DIV_LAT_C  = CTR_W'(DIV_LAT);

   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   mdop_e       op_q, op_d;

   logic        is_mul, is_div, accept, done;
   logic [CTR_W-1:0] load_val;

   // ---------------------------------------------------------------- decode
   always_comb begin
      is_mul = (mdop == MDOP_MULT) || (mdop == MDOP_MULTU);
`ifdef MDU_MADD_EN
      is_mul = is_mul || (mdop == MDOP_MADD) || (mdop == MDOP_MADDU);
`endif
      is_div = (mdop == MDOP_DIV) || (mdop == MDOP_DIVU);
   end

   // Ops are only accepted while idle; a start during the final busy cycle
   // is dropped because the unit is not idle on that edge.
   assign accept   = start && !busy && (is_mul || is_div);
   assign load_val = is_div ? DIV_LAT_C : MULT_LAT_C;

   mdu_busy_ctr u_ctr (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept),
      .load_val_i (load_val),
      .busy_o     (busy),
      .done_o     (done)
   );

   // ------------------------------------------------------------ arithmetic
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] a_mag, b_mag, b_safe;
   logic        [31:0] uq_mag, ur_mag, q_s, r_s, q_u, r_u;
   logic               div_zero;

   assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // A zero divisor is replaced by 1 so the dividers never see /0; the
   // result is discarded in that case anyway.
   assign div_zero = (b_q == 32'd0);
   assign b_safe   = div_zero ? 32'd1 : b_q;

   // Signed divide via magnitudes. 0x80000000 / -1 falls out naturally:
   // magnitude quotient 0x80000000, positive sign, remainder 0.
   assign a_mag  = a_q[31]    ? (~a_q + 32'd1)    : a_q;
   assign b_mag  = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
   assign uq_mag = a_mag / b_mag;
   assign ur_mag = a_mag % b_mag;
   assign q_s    = (a_q[31] ^ b_safe[31]) ? (~uq_mag + 32'd1) : uq_mag;
   assign r_s    = a_q[31] ? (~ur_mag + 32'd1) : ur_mag;
   assign q_u    = a_q / b_safe;
   assign r_u    = a_q % b_safe;

`ifdef MDU_MADD_EN
   logic [63:0] acc_s, acc_u;
   assign acc_s = {hi_q, lo_q} + prod_s;
   assign acc_u = {hi_q, lo_q} + prod_u;
`endif

   // ------------------------------------------------------- next-state logic
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      a_d  = a_q;
      b_d  = b_q;
      op_d = op_q;

      if (accept) begin
         a_d  = A;
         b_d  = B;
         op_d = mdop_e'(mdop);
      end else if (start && !busy) begin
         if (mdop == MDOP_MTHI) begin
            hi_d = A;
         end else if (mdop == MDOP_MTLO) begin
            lo_d = A;
         end
      end

      // done implies busy, so it never coincides with accept or MTHI/MTLO.
      if (done) begin
         case (op_q)
            MDOP_MULT:  {hi_d, lo_d} = prod_s;
            MDOP_MULTU: {hi_d, lo_d} = prod_u;
            MDOP_DIV: begin
               if (!div_zero) begin
                  lo_d = q_s;
                  hi_d = r_s;
               end
            end
            MDOP_DIVU: begin
               if (!div_zero) begin
                  lo_d = q_u;
                  hi_d = r_u;
               end
            end
`ifdef MDU_MADD_EN
            MDOP_MADD:  {hi_d, lo_d} = acc_s;
            MDOP_MADDU: {hi_d, lo_d} = acc_u;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_q <= '0;
         lo_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         op_q <= MDOP_NONE;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         a_q  <= a_d;
         b_q  <= b_d;
         op_q <= op_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_mdu_e.sv
// -----------------------------------------------------------------------------
// tb_mdu_e
// Directed table-driven bench for mdu_e plus hand-written sequences for the
// stray-start, start-on-completion and mid-operation reset cases.
// MADD/MADDU expectations follow MDU_MADD_EN.
// -----------------------------------------------------------------------------
module tb_mdu_e;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdop;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] hi, lo;

   always #5 clk = ~clk;

   mdu_e dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mdop  (mdop),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vec [NVEC];

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, count busy cycles (bounded), check hold and final result.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm);
      int n;
      start = 1'b1; mdop = op; A = a; B = b;
      step();
      start = 1'b0; mdop = OP_NONE;
      n = 0;
      while (busy && n < 20) begin
         chk({nm, " hold_hi"}, hi, m_hi);
         chk({nm, " hold_lo"}, lo, m_lo);
         step();
         n++;
      end
      chk({nm, " busy_cycles"}, 32'(n), 32'(lat));
      chk({nm, " hi"}, hi, ehi);
      chk({nm, " lo"}, lo, elo);
      $display("%s op=%0d A=%h B=%h busy_cycles=%0d hi=%h lo=%h", nm, op, a, b, n, hi, lo);
      m_hi = ehi;
      m_lo = elo;
   endtask

   initial begin
      int n;

      vec[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
      vec[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
      vec[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vec[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
      vec[4]  = '{OP_MTHI,  32'h00000011, 32'h0,        0,  32'h00000011, 32'h00000003};
      vec[5]  = '{OP_MTLO,  32'h00000022, 32'h0,        0,  32'h00000011, 32'h00000022};
      vec[6]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 10, 32'h00000011, 32'h00000022};
      vec[7]  = '{OP_NONE,  32'h12345678, 32'h9,        0,  32'h00000011, 32'h00000022};
      vec[8]  = '{4'd15,    32'h12345678, 32'h9,        0,  32'h00000011, 32'h00000022};
      vec[9]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      vec[10] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
      vec[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
      vec[12] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
      vec[13] = '{OP_MTHI,  32'h00000000, 32'h0,        0,  32'h00000000, 32'h00000001};
      vec[14] = '{OP_MTLO,  32'hFFFFFFFF, 32'h0,        0,  32'h00000000, 32'hFFFFFFFF};
`ifdef MDU_MADD_EN
      vec[15] = '{OP_MADDU, 32'h00000001, 32'h00000001, 5,  32'h00000001, 32'h00000000};
      vec[16] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000001, 5,  32'h00000000, 32'hFFFFFFFF};
`else
      vec[15] = '{OP_MADDU, 32'h00000001, 32'h00000001, 0,  32'h00000000, 32'hFFFFFFFF};
      vec[16] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000001, 0,  32'h00000000, 32'hFFFFFFFF};
`endif
      vec[17] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003};

      reset = 1'b0; start = 1'b0; mdop = OP_NONE; A = '0; B = '0;
      step();
      step();
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      reset = 1'b1;
      step();

      for (int i = 0; i < NVEC; i++) begin
         do_op(vec[i].op, vec[i].a, vec[i].b, vec[i].lat, vec[i].ehi, vec[i].elo,
               $sformatf("vec%0d", i));
      end

      // Stray DIV during MULT busy cycle 2 must be ignored.
      start = 1'b1; mdop = OP_MULT; A = 32'd3; B = 32'd4;
      step();
      start = 1'b0; mdop = OP_NONE;
      n = 0;
      while (busy && n < 20) begin
         if (n == 1) begin
            start = 1'b1; mdop = OP_DIV; A = 32'd100; B = 32'd7;
         end
         step();
         start = 1'b0; mdop = OP_NONE;
         n++;
      end
      chk("stray_div busy_cycles", 32'(n), 32'd5);
      chk("stray_div hi", hi, 32'd0);
      chk("stray_div lo", lo, 32'd12);
      step();
      chk("stray_div idle_after", 32'(busy), 32'd0);
      $display("stray_div busy_cycles=%0d hi=%h lo=%h", n, hi, lo);

      // MTHI on the completion edge of a MULT must be ignored.
      start = 1'b1; mdop = OP_MULT; A = 32'd3; B = 32'd5;
      step();
      start = 1'b0; mdop = OP_NONE;
      n = 0;
      while (busy && n < 20) begin
         if (n == 4) begin
            start = 1'b1; mdop = OP_MTHI; A = 32'h0000DEAD;
         end
         step();
         start = 1'b0; mdop = OP_NONE;
         n++;
      end
      chk("done_edge busy_cycles", 32'(n), 32'd5);
      chk("done_edge hi", hi, 32'd0);
      chk("done_edge lo", lo, 32'd15);
      step();
      chk("done_edge idle_after", 32'(busy), 32'd0);
      chk("done_edge hi_after", hi, 32'd0);
      $display("done_edge busy_cycles=%0d hi=%h lo=%h", n, hi, lo);
      m_hi = 32'd0;
      m_lo = 32'd15;

      // Reset on DIVU busy cycle 4 clears everything with no late write.
      do_op(OP_MTHI, 32'h00000055, 32'h0, 0, 32'h00000055, 32'd15, "pre_reset_mthi");
      start = 1'b1; mdop = OP_DIVU; A = 32'd100; B = 32'd7;
      step();
      start = 1'b0; mdop = OP_NONE;
      for (int k = 0; k < 3; k++) begin
         step();
      end
      chk("mid_reset busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mid_reset busy", 32'(busy), 32'd0);
      chk("mid_reset hi", hi, 32'd0);
      chk("mid_reset lo", lo, 32'd0);
      for (int k = 0; k < 12; k++) begin
         step();
      end
      chk("mid_reset late_busy", 32'(busy), 32'd0);
      chk("mid_reset late_hi", hi, 32'd0);
      chk("mid_reset late_lo", lo, 32'd0);
      $display("mid_reset busy=%0d hi=%h lo=%h", busy, hi, lo);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu_e.md
Name: mdu_e

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline. Sits downstream of the D-stage forwarding muxes: the forwarded operands are registered through D/E and arrive here.
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency with a busy flag.
- The hazard unit uses start|busy to stall D-stage mult/div/mf*/mt* instructions.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15.
- DIV_LAT, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; asserted when 0, sampled on rising edge of clk.
- start  input  1  E-stage instruction is an MDU op; qualifies mdop.
- mdop  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; 9..15 reserved.
- A  input  32  rs operand (forwarded E value).
- B  input  32  rt operand (forwarded E value).
- busy  output  1  operation in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (reset==0 at an edge): hi=0, lo=0, busy=0, counter=0, latched operands=0. Reset overrides everything, including an in-flight op. No result is written after a reset.
- States: IDLE (busy=0) and RUN (busy=1). Implemented as a 4-bit down-counter; busy = (counter != 0).
- IDLE, start=1, mdop in MULT..DIVU (or MADD/MADDU when enabled):
  - Latch A, B, mdop.
  - Load counter with MULT_LAT or DIV_LAT.
  - busy is 1 from the next cycle for exactly LAT cycles.
- RUN: counter decrements each edge. On the edge where counter==1:
  - hi/lo take the result.
  - busy falls to 0 on that same edge.
  - hi/lo hold their old values while busy=1.
- Results:
  - MULT: {hi,lo} = signed 64-bit A*B.
  - MULTU: {hi,lo} = unsigned 64-bit A*B.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- Divide by zero: full DIV_LAT busy period still occurs; hi and lo are left unchanged.
- DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO with start=1 in IDLE: hi (resp. lo) = A on the next edge. No busy cycles.
- start=1 while busy=1: ignored; operands are not relatched and the counter is unaffected. The hazard unit guarantees this does not occur; the unit must still be safe if it does.
- start=1 on the same edge busy falls (counter==1): ignored, because the unit is not IDLE on that edge.
- mdop NONE or reserved with start=1: no effect.
- Reads (mfhi/mflo) use hi/lo combinationally in E. There is no internal read bypass.

Optional Feature:
- MDU_MADD_EN
  - Defined: mdop 7 (MADD) gives {hi,lo} = {hi,lo} + signed A*B; mdop 8 (MADDU) is the unsigned form. Both take MULT_LAT busy cycles. The accumulation uses the hi/lo values present when the op completes.
  - Undefined: mdop 7 and 8 are reserved and have no effect.

Decomposition:
- Shared package mdu_pkg: mdop encodings (MDOP_NONE..MDOP_MADDU), default MULT_LAT/DIV_LAT constants, counter width.
- One sub-module, mdu_busy_ctr: the latency down-counter with load, decrement, busy and done-pulse outputs.
- Arithmetic and HI/LO registers stay in mdu_e.

Test Plan:
- MULT, A=0xFFFFFFFF, B=0x00000002 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with A=7, B=2 -> lo=3, hi=1.
- hi=0x11, lo=0x22 preloaded via MTHI/MTLO (each 1 cycle, busy stays 0), then DIVU with B=0 -> busy for 10 cycles, hi/lo remain 0x11/0x22.
- MULT started, start=1 with DIV on busy cycle 2 -> DIV ignored, MULT result lands at cycle 5, busy=0 afterwards.
- DIV started, reset=0 on busy cycle 4 -> next cycle busy=0, hi=lo=0, and no late write.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU A=1, B=1 -> hi=0x00000001, lo=0x00000000 after 5 cycles.
